vel_dac_scheduler: RTL and testbench
====================================

Name: vel_dac_scheduler

Overview:
- Shares the single DAC write interface among NUM_CH per-axis velocity controllers.
- Captures each controller's new output on the rising edge of its ready flag and holds it pending.
- Issues pending writes in round-robin order, using a request/busy handshake with the DAC module.
- Reports per-channel overruns and DAC handshake timeouts to status registers.

Parameters:
- NUM_CH, 4, number of controller channels (2..8).
- DATA_W, 16, DAC code width (offset-binary; midscale 16'h8000).
- ACK_TIMEOUT, 64, clk cycles to wait for dac_busy to rise after a request.

Ports:
- clk  input  1  system clock (~49.152 MHz).
- rstn  input  1  asynchronous active-low reset.
- ch_enable  input  NUM_CH  per-channel controller enable.
- ch_ready  input  NUM_CH  per-channel output-ready level from each velocity controller.
- ch_data  input  NUM_CH*DATA_W  packed controller outputs; channel k is at [k*DATA_W +: DATA_W].
- dac_busy  input  1  DAC module busy (high while shifting).
- dac_req  output  1  one-cycle write request pulse.
- dac_ch  output  3  target channel index, valid with dac_req.
- dac_data  output  DATA_W  DAC code, valid with dac_req.
- pending  output  NUM_CH  per-channel pending flags.
- overrun  output  NUM_CH  sticky flag: a new sample overwrote an unsent one.
- timeout_err  output  1  sticky flag: dac_busy did not rise within ACK_TIMEOUT.
- status_clr  input  1  clears overrun and timeout_err.

Behaviour:
- Reset: all outputs 0; dac_data = 16'h8000; state = IDLE; round-robin pointer = 0; all captured data = 16'h8000.
- Clocking: one clock (clk); reset rstn is asynchronous, active-low.
- Synchronization: ch_ready passes through a 2-flop synchronizer, then rising-edge detection (edge = sync & ~prev).
- Capture on edge of channel k while ch_enable[k] = 1:
  - data_reg[k] <= ch_data[k]; pending[k] <= 1.
  - If pending[k] was already 1 and is not being granted this cycle, set overrun[k].
- ch_enable[k] low: pending[k] cleared at once; edges on channel k are ignored.
- FSM states:
  - IDLE: when any pending bit is set and dac_busy = 0, grant the first pending channel at or after the pointer (wrap at NUM_CH-1 -> 0). Drive dac_req = 1 for one cycle with dac_ch/dac_data, clear pending[grant], set pointer = grant + 1 (mod NUM_CH), go to WAIT_ACK.
  - WAIT_ACK: dac_busy = 1 -> WAIT_DONE. If the counter reaches ACK_TIMEOUT -> set timeout_err, go to IDLE (sample dropped, no retry).
  - WAIT_DONE: dac_busy = 0 -> IDLE.
- dac_ch and dac_data hold their values until the next request.
- Latency: edge on ch_ready to dac_req is 3 cycles minimum (2 sync + 1 grant) when idle.
- Capture on the same cycle the channel is granted: the grant sends the old data_reg; the new value is captured, pending stays 1, and overrun is not set.
- Simultaneous status_clr and a new overrun/timeout event: the set wins.
- dac_busy already high in IDLE: no request is issued until it falls.
- Reset mid-transaction: returns to IDLE with pending cleared; an in-flight DAC write is not aborted.

Optional Feature:
- Macro: VEL_DAC_SAFE_MIDSCALE_EN.
- Defined: on a falling edge of ch_enable[k], data_reg[k] <= 16'h8000 and pending[k] <= 1, so zero current is commanded once. This pending bit is not cleared by the disabled state until it is sent.
- Undefined: disable simply clears pending[k]; the last code written remains on the DAC.

Decomposition:
- Shared package: DAC_MIDSCALE = 16'h8000; FSM state encodings IDLE/WAIT_ACK/WAIT_DONE; a CH_IDX_W function (clog2 of NUM_CH).
- Sub-module: rr_pick, a combinational round-robin priority picker (pending mask and pointer in, grant index and valid out), reusable by other arbiters.

Test Plan:
- Single channel: ch_ready[2] rises with data 16'h9000, dac_busy idle -> dac_req 3 cycles later, dac_ch = 2, dac_data = 16'h9000, pending[2] clears.
- All four channels ready on the same cycle, busy held 128 cycles per write -> grants issued in order 0,1,2,3 with pointer wrap; next burst starts at 0; no overrun.
- Channel 1 produces two edges (16'h8100, then 16'h8200) while busy is held -> one write of 16'h8200; overrun[1] = 1 until status_clr.
- dac_busy never rises after a request -> timeout_err = 1 after 64 cycles; FSM returns to IDLE and serves the next pending channel.
- ch_enable[3] dropped while pending[3] = 1 -> with the macro, a write of 16'h8000 to channel 3; without it, no write and pending[3] = 0.
- rstn asserted during WAIT_DONE -> all outputs at reset values immediately; normal operation after release.

Source files
------------

// File: rtl/vel_dac_scheduler_pkg.sv
// vel_dac_scheduler_pkg: shared constants, FSM states and index-width helper for the DAC scheduler
package vel_dac_scheduler_pkg;
  localparam logic [15:0] DAC_MIDSCALE = 16'h8000;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vel_dac_scheduler_if.sv
// vel_dac_scheduler_if: request/busy write handshake between the scheduler and the DAC module
interface vel_dac_scheduler_if #(parameter int DATA_W = 16);
  logic dac_req;
  logic [2:0] dac_ch;
  logic [DATA_W-1:0] dac_data;
  logic dac_busy;
  modport master(output dac_req, dac_ch, dac_data, input dac_busy);
  modport slave(input dac_req, dac_ch, dac_data, output dac_busy);
endinterface

// File: rtl/vel_dac_scheduler_rr_pick.sv
// vel_dac_scheduler_rr_pick: combinational round-robin picker, first set request at or after ptr
module vel_dac_scheduler_rr_pick
  import vel_dac_scheduler_pkg::*;
#(
  parameter int N = 4,
  localparam int W = ch_idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic valid
);
  logic [W-1:0] j;
  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = W'((int'(ptr) + i) % N);
      if (req[j]) begin
        grant = j;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vel_dac_scheduler.sv
// vel_dac_scheduler: round-robin DAC write sharing for velocity controllers; option VEL_DAC_SAFE_MIDSCALE_EN
module vel_dac_scheduler
  import vel_dac_scheduler_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  vel_dac_scheduler_if.master dac,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overrun,
  output logic timeout_err,
  input  logic status_clr
);
  localparam int W = ch_idx_w(NUM_CH);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DATA_W-1:0] MID = DATA_W'(DAC_MIDSCALE);
  state_t state, state_n;
  logic [NUM_CH-1:0] sync1, sync2, prev, rise, fall, gmask, pending_n;
  logic [DATA_W-1:0] data_reg [NUM_CH];
  logic [DATA_W-1:0] data_q;
  logic [2:0] ch_q;
  logic [W-1:0] ptr, gnt;
  logic [CW-1:0] cnt;
  logic gvalid, go, tmo;

  vel_dac_scheduler_rr_pick #(.N(NUM_CH)) u_pick (
    .req(pending),
    .ptr(ptr),
    .grant(gnt),
    .valid(gvalid)
  );

`ifdef VEL_DAC_SAFE_MIDSCALE_EN
  logic [NUM_CH-1:0] en_prev;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) en_prev <= '0;
    else en_prev <= ch_enable;
  // A disabled channel keeps its midscale write pending until it is sent.
  assign fall = en_prev & ~ch_enable;
  assign pending_n = (pending & ~gmask) | rise | fall;
`else
  assign fall = '0;
  assign pending_n = ((pending & ~gmask) | rise) & ch_enable;
`endif

  always_comb begin
    rise = sync2 & ~prev & ch_enable;
    go = state == IDLE && gvalid && !dac.dac_busy;
    gmask = go ? NUM_CH'(1) << gnt : '0;
    tmo = state == WAIT_ACK && !dac.dac_busy && cnt == CW'(ACK_TIMEOUT - 1);
    state_n = go ? WAIT_ACK
      : state == WAIT_ACK ? (dac.dac_busy ? WAIT_DONE : tmo ? IDLE : WAIT_ACK)
      : state == WAIT_DONE && !dac.dac_busy ? IDLE : state;
  end

  // The request is issued combinationally from IDLE so the grant cycle sends the pre-capture data.
  assign dac.dac_req = go;
  assign dac.dac_ch = go ? 3'(gnt) : ch_q;
  assign dac.dac_data = go ? data_reg[gnt] : data_q;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
      prev <= '0;
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      ch_q <= '0;
      data_q <= MID;
      pending <= '0;
      overrun <= '0;
      timeout_err <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) data_reg[k] <= MID;
    end else begin
      sync1 <= ch_ready;
      sync2 <= sync1;
      prev <= sync2;
      state <= state_n;
      cnt <= state == WAIT_ACK ? cnt + 1'b1 : '0;
      if (go) begin
        ptr <= gnt == W'(NUM_CH - 1) ? '0 : gnt + 1'b1;
        ch_q <= 3'(gnt);
        data_q <= data_reg[gnt];
      end
      pending <= pending_n;
      overrun <= (overrun & ~{NUM_CH{status_clr}}) | (rise & pending & ~gmask);
      timeout_err <= (timeout_err & !status_clr) | tmo;
      for (int k = 0; k < NUM_CH; k++)
        if (fall[k] || rise[k]) data_reg[k] <= fall[k] ? MID : ch_data[k*DATA_W +: DATA_W];
    end
endmodule

// File: tb/tb_vel_dac_scheduler.sv
// tb_vel_dac_scheduler: directed scenarios plus randomized traffic against a transaction-level model
module tb_vel_dac_scheduler;
  localparam int N = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic status_clr = 1'b0;
  logic [N-1:0] ch_enable = '1;
  logic [N-1:0] ch_ready = '0;
  logic [N*DW-1:0] ch_data = '0;
  logic [N-1:0] pending, overrun;
  logic timeout_err;

  vel_dac_scheduler_if #(.DATA_W(DW)) dac();

  vel_dac_scheduler #(.NUM_CH(N), .DATA_W(DW), .ACK_TIMEOUT(64)) dut (
    .clk(clk),
    .rstn(rstn),
    .ch_enable(ch_enable),
    .ch_ready(ch_ready),
    .ch_data(ch_data),
    .dac(dac.master),
    .pending(pending),
    .overrun(overrun),
    .timeout_err(timeout_err),
    .status_clr(status_clr)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // DAC module stand-in
  bit dac_on = 1'b1;
  bit rnd = 1'b0;
  int ack_dly = 1;
  int busy_len = 4;
  initial begin
    dac.dac_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (dac_on && dac.dac_req === 1'b1) begin
        if (rnd) begin
          ack_dly = $urandom_range(1, 5);
          busy_len = $urandom_range(1, 30);
        end
        repeat (ack_dly) @(negedge clk);
        dac.dac_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        dac.dac_busy = 1'b0;
      end
    end
  end

  int nreq [8];
  always @(negedge clk) if (dac.dac_req === 1'b1) nreq[dac.dac_ch]++;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_req(input string tag, input int lim, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (dac.dac_req !== 1'b1 && lat < lim);
    if (dac.dac_req !== 1'b1) check({tag, "_noreq"}, 0, 1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(3);
    rstn = 1'b1;
    step(2);
  endtask

  task automatic set_data(input int k, input logic [15:0] d);
    ch_data[k*DW +: DW] = d;
  endtask

  // Transaction-level reference: captures land three cycles after a rise is driven.
  typedef struct {int due; int ch; logic [15:0] d;} ev_t;
  ev_t evq[$];
  logic [N-1:0] mpend, mover;
  logic [15:0] mdata [N];
  int mptr;
  int hold [N];
  bit clr_prev;

  task automatic model_cycle(input bit drive_on);
    int e;
    if (clr_prev) mover = '0;
    while (evq.size() > 0 && evq[0].due <= cyc) begin
      ev_t ev = evq.pop_front();
      if (mpend[ev.ch]) mover[ev.ch] = 1'b1;
      mpend[ev.ch] = 1'b1;
      mdata[ev.ch] = ev.d;
    end
    check("rnd_pending", pending, mpend);
    check("rnd_overrun", overrun, mover);
    if (dac.dac_req === 1'b1) begin
      e = -1;
      for (int i = 0; i < N; i++)
        if (e < 0 && mpend[(mptr + i) % N]) e = (mptr + i) % N;
      check("rnd_req_busy", dac.dac_busy, 0);
      check("rnd_req_any", e >= 0, 1);
      if (e >= 0) begin
        check("rnd_ch", dac.dac_ch, e);
        check("rnd_data", dac.dac_data, mdata[e]);
        mpend[e] = 1'b0;
        mptr = (e + 1) % N;
      end
    end
    clr_prev = drive_on && $urandom_range(59) == 0;
    status_clr = clr_prev;
    for (int k = 0; k < N; k++) begin
      if (ch_ready[k]) begin
        if (hold[k] >= 2 && $urandom_range(3) == 0) begin
          ch_ready[k] = 1'b0;
          hold[k] = 0;
        end else hold[k]++;
      end else if (drive_on && hold[k] >= 2 && $urandom_range(15) == 0) begin
        logic [15:0] d = 16'($urandom);
        set_data(k, d);
        ch_ready[k] = 1'b1;
        hold[k] = 0;
        evq.push_back('{cyc + 3, k, d});
      end else hold[k]++;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, n1, n3;
    // reset values
    step(3);
    check("rst_req", dac.dac_req, 0);
    check("rst_ch", dac.dac_ch, 0);
    check("rst_data", dac.dac_data, 16'h8000);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout_err, 0);
    rstn = 1'b1;
    step(2);

    // single channel latency
    set_data(2, 16'h9000);
    ch_ready[2] = 1'b1;
    wait_req("single", 20, lat);
    check("single_lat", lat, 3);
    check("single_ch", dac.dac_ch, 2);
    check("single_data", dac.dac_data, 16'h9000);
    step();
    check("single_pend", pending[2], 0);
    ch_ready[2] = 1'b0;
    step(20);

    // all channels at once, long busy, pointer wrap
    do_reset();
    busy_len = 128;
    for (int k = 0; k < N; k++) set_data(k, 16'hA000 + 16'(k));
    ch_ready = '1;
    for (int k = 0; k < N; k++) begin
      wait_req("burst", 300, lat);
      check("burst_ch", dac.dac_ch, k);
      check("burst_data", dac.dac_data, 16'hA000 + k);
    end
    busy_len = 4;
    check("burst_overrun", overrun, 0);
    ch_ready = '0;
    step(5);
    for (int k = 0; k < N; k++) set_data(k, 16'hB000 + 16'(k));
    ch_ready = '1;
    for (int k = 0; k < N; k++) begin
      wait_req("burst2", 300, lat);
      check("burst2_ch", dac.dac_ch, k);
      check("burst2_data", dac.dac_data, 16'hB000 + k);
    end
    step(20);
    ch_ready = '0;
    step(5);

    // overrun on channel 1 while busy
    busy_len = 40;
    set_data(0, 16'h1111);
    ch_ready[0] = 1'b1;
    wait_req("ovr0", 20, lat);
    check("ovr0_ch", dac.dac_ch, 0);
    set_data(1, 16'h8100);
    ch_ready[1] = 1'b1;
    step(4);
    ch_ready[1] = 1'b0;
    step(3);
    set_data(1, 16'h8200);
    ch_ready[1] = 1'b1;
    step(4);
    check("ovr_pend", pending[1], 1);
    check("ovr_flag", overrun, 4'b0010);
    n1 = nreq[1];
    busy_len = 4;
    wait_req("ovr1", 100, lat);
    check("ovr1_ch", dac.dac_ch, 1);
    check("ovr1_data", dac.dac_data, 16'h8200);
    step(60);
    check("ovr1_count", nreq[1] - n1, 1);
    check("ovr_sticky", overrun[1], 1);
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check("ovr_clr", overrun, 0);

    // handshake timeout then next channel served
    ch_ready[1:0] = 2'b00;
    step(3);
    dac_on = 1'b0;
    set_data(2, 16'h2222);
    set_data(3, 16'h3333);
    ch_ready[3:2] = 2'b11;
    n3 = nreq[3];
    wait_req("tmo", 20, lat);
    check("tmo_ch", dac.dac_ch, 2);
    step(60);
    check("tmo_early", timeout_err, 0);
    step(6);
    check("tmo_set", timeout_err, 1);
    check("tmo_next_cnt", nreq[3] - n3, 1);
    check("tmo_next_ch", dac.dac_ch, 3);
    check("tmo_next_data", dac.dac_data, 16'h3333);
    step(70);
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check("tmo_clr", timeout_err, 0);
    check("tmo_pend", pending, 0);
    dac_on = 1'b1;

    // enable drop while pending
    ch_ready[3:2] = 2'b00;
    step(3);
    busy_len = 40;
    set_data(0, 16'h4444);
    ch_ready[0] = 1'b1;
    wait_req("en0", 20, lat);
    set_data(3, 16'h5555);
    ch_ready[3] = 1'b1;
    step(4);
    check("en_pend_before", pending[3], 1);
    ch_enable[3] = 1'b0;
    step(2);
    n3 = nreq[3];
`ifdef VEL_DAC_SAFE_MIDSCALE_EN
    check("en_pend_safe", pending[3], 1);
    wait_req("en_safe", 100, lat);
    check("en_safe_ch", dac.dac_ch, 3);
    check("en_safe_data", dac.dac_data, 16'h8000);
`else
    check("en_pend_drop", pending[3], 0);
    step(60);
    check("en_no_write", nreq[3] - n3, 0);
`endif
    busy_len = 4;
    ch_ready[3] = 1'b0;
    step(3);
    ch_enable[3] = 1'b1;
    step(50);

    // reset during WAIT_DONE
    ch_ready[0] = 1'b0;
    step(3);
    busy_len = 30;
    set_data(0, 16'h6666);
    ch_ready[0] = 1'b1;
    wait_req("rmid", 20, lat);
    set_data(2, 16'h7777);
    ch_ready[2] = 1'b1;
    step(5);
    check("rmid_pend_pre", pending[2], 1);
    rstn = 1'b0;
    #1;
    check("rmid_req", dac.dac_req, 0);
    check("rmid_ch", dac.dac_ch, 0);
    check("rmid_data", dac.dac_data, 16'h8000);
    check("rmid_pend", pending, 0);
    ch_ready[2] = 1'b0;
    ch_ready[0] = 1'b0;
    step(2);
    rstn = 1'b1;
    busy_len = 4;
    set_data(1, 16'h7171);
    ch_ready[1] = 1'b1;
    wait_req("rmid_after", 100, lat);
    check("rmid_after_ch", dac.dac_ch, 1);
    check("rmid_after_data", dac.dac_data, 16'h7171);
    step(20);
    ch_ready = '0;
    step(5);

    // randomized traffic against the model
    do_reset();
    rnd = 1'b1;
    mpend = '0;
    mover = '0;
    mptr = 0;
    clr_prev = 1'b0;
    for (int k = 0; k < N; k++) begin
      mdata[k] = 16'h8000;
      hold[k] = 2;
    end
    for (int i = 0; i < 4000; i++) begin
      step();
      model_cycle(1'b1);
    end
    for (int i = 0; i < 800 && (mpend != 0 || evq.size() > 0); i++) begin
      step();
      model_cycle(1'b0);
    end
    check("rnd_drained", {28'b0, mpend}, 0);
    check("rnd_timeout", timeout_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
